// File: rtl/period_cap_pkg.sv
// Shared types and constants for the period capture block.
package period_cap_pkg;

    // Default counter / result width in bits.
    localparam int PC_WIDTH   = 8;
    // Saturation value of the period counter at the default width.
    localparam int PC_CNT_MAX = 2**PC_WIDTH - 1;
    // Shortest interval an edge detector can see (high, low, high).
    localparam int MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2
    } state_e;

endpackage

// File: rtl/sat_cntr_8bit.sv
// Saturating up-counter: clear to 0, load to 1, or count up while enabled,
// holding at MAX instead of wrapping. at_max_o flags the saturated value.
module sat_cntr_8bit #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             at_max_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign at_max_o = (cnt_q == MAX);
    assign cnt_o    = cnt_q;

    // Next count: clear beats load, load beats increment; never pass MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = WIDTH'(1);
        end else if (en_i && !at_max_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/period_capture_8bit.sv
// Measures clk cycles between consecutive rising edges of evt_in and
// presents the result on a held register with a valid/ack handshake.
module period_capture_8bit
    import period_cap_pkg::*;
#(
    parameter int WIDTH   = PC_WIDTH,
    parameter int CNT_MAX = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             stop,
    input  logic             cont,
    input  logic             evt_in,
    input  logic             ack,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             ovf,
    output logic             busy,
    output logic             lost
);

    state_e           state_q;
    logic             evt_q;
    logic             ovf_pend_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             ovf_q;
    logic             lost_q;

    logic             evt_edge;
    logic             capture;
    logic             cnt_clr;
    logic             cnt_load;
    logic             cnt_en;
    logic [WIDTH-1:0] cnt;
    logic             cnt_at_max;

    // Same-cycle rising edge: current input high, previous sample low.
    assign evt_edge = evt_in & ~evt_q;

    // A capture is an edge during MEASURE that stop does not override.
    assign capture  = (state_q == MEASURE) && evt_edge && !stop;

    // Counter control: stop clears, an edge that opens a period loads 1,
    // otherwise count while measuring.
    assign cnt_clr  = stop && (state_q != IDLE);
    assign cnt_load = !stop && evt_edge &&
                      ((state_q == WAIT_FIRST) || ((state_q == MEASURE) && cont));
    assign cnt_en   = (state_q == MEASURE) && !evt_edge && !stop;

    sat_cntr_8bit #(
        .WIDTH (WIDTH),
        .MAX   (WIDTH'(CNT_MAX))
    ) u_cntr (
        .clk      (clk),
        .rst_n    (rst),
        .clr_i    (cnt_clr),
        .load_i   (cnt_load),
        .en_i     (cnt_en),
        .cnt_o    (cnt),
        .at_max_o (cnt_at_max)
    );

    // Previous-cycle copy of the event input for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_q <= 1'b0;
        end else begin
            evt_q <= evt_in;
        end
    end

    // Control FSM plus result register, overflow tracking and handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ovf_pend_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // An edge coinciding with arm is deliberately not used.
                    if (arm && !stop) begin
                        state_q <= WAIT_FIRST;
                        lost_q  <= 1'b0;
                    end
                end
                WAIT_FIRST: begin
                    if (stop) begin
                        state_q <= IDLE;
                    end else if (evt_edge) begin
                        state_q    <= MEASURE;
                        ovf_pend_q <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (stop) begin
                        state_q <= IDLE;
                    end else if (evt_edge) begin
                        // The capturing edge also opens the next period.
                        ovf_pend_q <= 1'b0;
                        state_q    <= cont ? MEASURE : IDLE;
                    end else if (cnt_at_max) begin
                        // Held at the ceiling for another cycle: true period exceeds it.
                        ovf_pend_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Result register: load when free or being freed this cycle.
            if (capture) begin
                if (!valid_q || ack) begin
                    data_q  <= cnt;
                    ovf_q   <= ovf_pend_q;
                    valid_q <= 1'b1;
                end else begin
                    lost_q  <= 1'b1;
                end
            end else if (ack && valid_q) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign ovf      = ovf_q;
    assign lost     = lost_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_period_capture_8bit.sv
// Directed bench for period_capture_8bit.
module tb_period_capture_8bit;

    logic       clk;
    logic       rst;
    logic       arm;
    logic       stop;
    logic       cont;
    logic       evt_in;
    logic       ack;
    logic [7:0] data_out;
    logic       valid;
    logic       ovf;
    logic       busy;
    logic       lost;

    int n_vec;
    int n_err;

    period_capture_8bit dut (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .stop     (stop),
        .cont     (cont),
        .evt_in   (evt_in),
        .ack      (ack),
        .data_out (data_out),
        .valid    (valid),
        .ovf      (ovf),
        .busy     (busy),
        .lost     (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_edge();
        evt_in = 1'b1;
        tick();
        evt_in = 1'b0;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // Single-shot measurement of period p (p >= 2).
    task automatic measure_single(input int p);
        cont = 1'b0;
        arm_pulse();
        send_edge();
        wait_cyc(p - 1);
        send_edge();
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst    = 1'b0;
        arm    = 1'b0;
        stop   = 1'b0;
        cont   = 1'b0;
        evt_in = 1'b0;
        ack    = 1'b0;
        wait_cyc(3);
        check_val("rst_data", data_out, 0);
        check_val("rst_valid", valid, 0);
        check_val("rst_busy", busy, 0);
        rst = 1'b1;
        tick();

        // Edges 7 cycles apart, single shot.
        measure_single(7);
        check_val("p7_data", data_out, 7);
        check_val("p7_valid", valid, 1);
        check_val("p7_ovf", ovf, 0);
        check_val("p7_busy", busy, 0);
        ack_pulse();
        check_val("p7_ack_valid", valid, 0);

        // Leave a sample pending, then reset in the middle of a 40-cycle period.
        measure_single(3);
        check_val("p3_valid", valid, 1);
        arm_pulse();
        send_edge();
        wait_cyc(19);
        rst = 1'b0;
        #1;
        check_val("mid_rst_data", data_out, 0);
        check_val("mid_rst_valid", valid, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_lost", lost, 0);
        check_val("mid_rst_ovf", ovf, 0);
        tick();
        rst = 1'b1;
        tick();
        measure_single(12);
        check_val("p12_data", data_out, 12);
        check_val("p12_valid", valid, 1);
        ack_pulse();

        // Boundary periods.
        measure_single(2);
        check_val("p2_data", data_out, 2);
        check_val("p2_ovf", ovf, 0);
        ack_pulse();
        measure_single(255);
        check_val("p255_data", data_out, 255);
        check_val("p255_ovf", ovf, 0);
        ack_pulse();
        measure_single(256);
        check_val("p256_data", data_out, 255);
        check_val("p256_ovf", ovf, 1);
        ack_pulse();
        measure_single(300);
        check_val("p300_data", data_out, 255);
        check_val("p300_ovf", ovf, 1);
        ack_pulse();
        check_val("p300_ack_valid", valid, 0);

        // Continuous, no ack: second sample dropped.
        cont = 1'b1;
        arm_pulse();
        send_edge();
        wait_cyc(4);
        send_edge();
        check_val("c_noack_first", data_out, 5);
        wait_cyc(8);
        send_edge();
        check_val("c_noack_data", data_out, 5);
        check_val("c_noack_lost", lost, 1);
        check_val("c_noack_busy", busy, 1);
        stop_pulse();
        check_val("c_noack_stop_busy", busy, 0);
        check_val("c_noack_stop_valid", valid, 1);
        ack_pulse();

        // Continuous with ack after each sample.
        arm_pulse();
        check_val("c_ack_lost_clr", lost, 0);
        send_edge();
        wait_cyc(4);
        send_edge();
        check_val("c_ack_first", data_out, 5);
        ack_pulse();
        wait_cyc(7);
        send_edge();
        check_val("c_ack_second", data_out, 9);
        check_val("c_ack_lost", lost, 0);
        stop_pulse();
        ack_pulse();

        // Continuous with ack coinciding with the second capture.
        arm_pulse();
        send_edge();
        wait_cyc(4);
        send_edge();
        check_val("c_coin_first", data_out, 5);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_val("c_coin_hold_valid", valid, 1);
        end
        evt_in = 1'b1;
        ack    = 1'b1;
        tick();
        evt_in = 1'b0;
        ack    = 1'b0;
        check_val("c_coin_second", data_out, 9);
        check_val("c_coin_valid", valid, 1);
        check_val("c_coin_lost", lost, 0);
        stop_pulse();
        ack_pulse();

        // Stop coinciding with the second edge: no capture.
        cont = 1'b0;
        arm_pulse();
        send_edge();
        wait_cyc(4);
        evt_in = 1'b1;
        stop   = 1'b1;
        tick();
        evt_in = 1'b0;
        stop   = 1'b0;
        check_val("stop_valid", valid, 0);
        check_val("stop_busy", busy, 0);

        // Arm while busy is ignored; the measurement carries on.
        arm_pulse();
        send_edge();
        wait_cyc(3);
        arm_pulse();
        check_val("arm_busy_busy", busy, 1);
        wait_cyc(1);
        send_edge();
        check_val("arm_busy_data", data_out, 6);
        check_val("arm_busy_idle", busy, 0);
        ack_pulse();

        // An edge in the arm cycle does not start the period.
        arm    = 1'b1;
        evt_in = 1'b1;
        tick();
        arm    = 1'b0;
        evt_in = 1'b0;
        wait_cyc(3);
        send_edge();
        wait_cyc(6);
        send_edge();
        check_val("arm_edge_data", data_out, 7);
        ack_pulse();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
